// File: rtl/utm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : utm_pkg
// Purpose  : Shared symbol, direction and FSM definitions for the UTM slice.
// Revision : 1.0
// ============================================================================
package utm_pkg;

    localparam int              SYM_W     = 3;
    localparam logic [SYM_W-1:0] BLANK_SYM = '0;
    localparam logic [SYM_W-1:0] HALT_SYM  = 3'b111;
    localparam logic            DIR_LEFT  = 1'b0;
    localparam logic            DIR_RIGHT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/utm_tape_ram.sv
`default_nettype none
// ============================================================================
// Module   : utm_tape_ram
// Purpose  : Flop-based tape with one muxed write port and two async reads.
// Revision : 1.0
// ============================================================================
module utm_tape_ram #(
    parameter int TAPE_DEPTH = 16,
    parameter int SYM_W      = 3,
    localparam int AW        = $clog2(TAPE_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [SYM_W-1:0] host_sym,
    input  logic             seq_we,
    input  logic [AW-1:0]    seq_addr,
    input  logic [SYM_W-1:0] seq_sym,
    input  logic [AW-1:0]    head_addr,
    output logic [SYM_W-1:0] head_sym,
    input  logic [AW-1:0]    rd_addr,
    output logic [SYM_W-1:0] rd_sym
);
    import utm_pkg::*;

    logic [SYM_W-1:0] r_cells [TAPE_DEPTH];
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [SYM_W-1:0] w_wdata;

    // Host and sequencer never write together; sequencer wins regardless.
    always_comb begin
        w_we    = host_we | seq_we;
        w_waddr = host_addr;
        w_wdata = host_sym;
        if (seq_we) begin
            w_waddr = seq_addr;
            w_wdata = seq_sym;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPE_DEPTH; i++) begin
                r_cells[i] <= SYM_W'(BLANK_SYM);
            end
        end else if (w_we) begin
            r_cells[w_waddr] <= w_wdata;
        end
    end

    assign head_sym = r_cells[head_addr];
    assign rd_sym   = r_cells[rd_addr];

endmodule
`default_nettype wire

// File: rtl/utm_tape_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : utm_tape_sequencer
// Purpose  : Owns the tape and steps utm_core: read, issue, wait, write, move.
// Revision : 1.0
// ============================================================================
module utm_tape_sequencer #(
    parameter int               TAPE_DEPTH   = 16,
    parameter int               SYM_W        = utm_pkg::SYM_W,
    parameter int               CORE_LATENCY = 8,
    parameter logic [SYM_W-1:0] HALT_SYM     = SYM_W'(utm_pkg::HALT_SYM),
    localparam int              AW           = $clog2(TAPE_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    start_head,
    input  logic [15:0]      step_limit,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [SYM_W-1:0] load_sym,
    output logic [SYM_W-1:0] rd_sym,
    output logic [SYM_W-1:0] core_sym,
    output logic             core_sym_valid,
    input  logic [SYM_W-1:0] core_new_sym,
    input  logic             core_direction,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [AW-1:0]    head,
    output logic [15:0]      step_count
);
    import utm_pkg::*;

    localparam int            CW          = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY) : 1;
    localparam logic [CW-1:0] c_WAIT_INIT = CW'(CORE_LATENCY - 1);
    localparam logic [AW-1:0] c_LAST_CELL = AW'(TAPE_DEPTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [AW-1:0]    r_head;
    logic [15:0]      r_limit;
    logic [15:0]      r_step_count;
    logic [SYM_W-1:0] r_core_sym;
    logic             r_core_sym_valid;
    logic             r_halted;
    logic             r_fault;
    logic [CW-1:0]    r_wait_cnt;

    logic             w_host_we;
    logic             w_seq_we;
    logic [SYM_W-1:0] w_head_sym;
    logic             w_is_halt;
    logic             w_at_edge;
    logic             w_limit_hit;
    logic [15:0]      w_step_inc;
    logic             w_idle_like;

    utm_tape_ram #(
        .TAPE_DEPTH (TAPE_DEPTH),
        .SYM_W      (SYM_W)
    ) u_tape (
        .clock      (clock),
        .reset      (reset),
        .host_we    (w_host_we),
        .host_addr  (load_addr),
        .host_sym   (load_sym),
        .seq_we     (w_seq_we),
        .seq_addr   (r_head),
        .seq_sym    (core_new_sym),
        .head_addr  (r_head),
        .head_sym   (w_head_sym),
        .rd_addr    (load_addr),
        .rd_sym     (rd_sym)
    );

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_host_we   = load_we && w_idle_like;
    assign w_is_halt   = (core_new_sym == HALT_SYM);
    assign w_seq_we    = (r_state == ST_WRITEBACK) && !w_is_halt;
    assign w_at_edge   = ((r_head == '0)         && (core_direction == DIR_LEFT)) ||
                         ((r_head == c_LAST_CELL) && (core_direction == DIR_RIGHT));
    assign w_step_inc  = (r_step_count == 16'hFFFF) ? r_step_count : r_step_count + 16'd1;
    // 16-bit wrap of FFFF+1 gives 0, which never matches a non-zero limit.
    assign w_limit_hit = (r_limit != 16'd0) && ((r_step_count + 16'd1) == r_limit);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == '0) w_next_state = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                if (w_is_halt || w_at_edge || w_limit_hit) w_next_state = ST_DONE;
                else                                       w_next_state = ST_ISSUE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head           <= '0;
            r_limit          <= '0;
            r_step_count     <= '0;
            r_core_sym       <= '0;
            r_core_sym_valid <= 1'b0;
            r_halted         <= 1'b0;
            r_fault          <= 1'b0;
            r_wait_cnt       <= '0;
        end else begin
            r_core_sym_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_head       <= start_head;
                        r_limit      <= step_limit;
                        r_step_count <= '0;
                        r_halted     <= 1'b0;
                        r_fault      <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_core_sym       <= w_head_sym;
                    r_core_sym_valid <= 1'b1;
                    r_wait_cnt       <= c_WAIT_INIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - CW'(1);
                end
                ST_WRITEBACK: begin
                    if (w_is_halt) begin
                        r_halted <= 1'b1;
                    end else begin
                        r_step_count <= w_step_inc;
                        if (w_at_edge) begin
                            r_fault <= 1'b1;
                        end else begin
                            r_head <= (core_direction == DIR_RIGHT) ? r_head + AW'(1)
                                                                    : r_head - AW'(1);
                            if (w_limit_hit) r_halted <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy           = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                            (r_state == ST_WRITEBACK);
    assign core_sym       = r_core_sym;
    assign core_sym_valid = r_core_sym_valid;
    assign halted         = r_halted;
    assign fault          = r_fault;
    assign head           = r_head;
    assign step_count     = r_step_count;

endmodule
`default_nettype wire

// File: tb/tb_utm_tape_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_utm_tape_sequencer
// Purpose  : Scoreboard bench with a step-level tape machine reference model.
// Revision : 1.0
// ============================================================================
module tb_utm_tape_sequencer;

    localparam int         DEPTH    = 16;
    localparam int         PERIOD   = 10;
    localparam int         MAXSTEPS = 64;
    localparam logic [2:0] HALT     = 3'b111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  start_head = '0;
    logic [15:0] step_limit = '0;
    logic        load_we = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [2:0]  load_sym = '0;
    logic [2:0]  rd_sym;
    logic [2:0]  core_sym;
    logic        core_sym_valid;
    logic [2:0]  core_new_sym = '0;
    logic        core_direction = 1'b0;
    logic        busy;
    logic        halted;
    logic        fault;
    logic [3:0]  head;
    logic [15:0] step_count;

    utm_tape_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .start_head(start_head),
        .step_limit(step_limit), .load_we(load_we), .load_addr(load_addr),
        .load_sym(load_sym), .rd_sym(rd_sym), .core_sym(core_sym),
        .core_sym_valid(core_sym_valid), .core_new_sym(core_new_sym),
        .core_direction(core_direction), .busy(busy), .halted(halted),
        .fault(fault), .head(head), .step_count(step_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int sym; int at; } pulse_t;
    typedef struct { int hd; int cnt; int hl; int fl; } status_t;

    pulse_t     pq[$];
    status_t    sq[$];
    logic [2:0] tape_m   [DEPTH];
    logic [2:0] resp_sym [MAXSTEPS];
    logic       resp_dir [MAXSTEPS];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Whole-run prediction from the step rules: read, halt?, write, edge?, move, limit?
    task automatic model_run(input int h0, input int lim, input int s);
        int h   = h0;
        int cnt = 0;
        int hl  = 0;
        int fl  = 0;
        for (int k = 0; k < MAXSTEPS; k++) begin
            pq.push_back('{int'(tape_m[h]), s + 2 + PERIOD * k});
            if (resp_sym[k] == HALT) begin hl = 1; break; end
            tape_m[h] = resp_sym[k];
            cnt++;
            if ((h == 0 && !resp_dir[k]) || (h == DEPTH - 1 && resp_dir[k])) begin
                fl = 1; break;
            end
            h = resp_dir[k] ? h + 1 : h - 1;
            if (lim != 0 && cnt == lim) begin hl = 1; break; end
        end
        sq.push_back('{h, cnt, hl, fl});
    endtask

    // Monitor and core responder share one negedge process.
    pulse_t  p;
    status_t st;
    int      idx = 0;
    logic    prev_busy = 1'b0;
    always @(negedge clock) begin
        if (core_sym_valid === 1'b1) begin
            if (pq.size() == 0) begin
                chk("unexpected_pulse", int'(core_sym_valid), 0);
            end else begin
                p = pq.pop_front();
                chk("pulse_sym", int'(core_sym), p.sym);
                chk("pulse_cycle", cyc, p.at);
            end
        end
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (sq.size() == 0) begin
                chk("unexpected_done", int'(busy), 1);
            end else begin
                st = sq.pop_front();
                chk("end_head", int'(head), st.hd);
                chk("end_step_count", int'(step_count), st.cnt);
                chk("end_halted", int'(halted), st.hl);
                chk("end_fault", int'(fault), st.fl);
                chk("pulses_left", pq.size(), 0);
            end
        end
        prev_busy = busy;
        if (busy !== 1'b1) begin
            idx = 0;
        end else if (core_sym_valid === 1'b1) begin
            core_new_sym   = resp_sym[idx];
            core_direction = resp_dir[idx];
            if (idx < MAXSTEPS - 1) idx++;
        end
    end

    task automatic fill_resp(input int halt_pct);
        for (int k = 0; k < MAXSTEPS; k++) begin
            resp_sym[k] = ($urandom_range(0, 99) < halt_pct) ? HALT : 3'($urandom_range(0, 6));
            resp_dir[k] = 1'($urandom_range(0, 1));
        end
        resp_sym[MAXSTEPS-1] = HALT;
    endtask

    task automatic host_write(input int a, input int v);
        @(negedge clock);
        load_we = 1'b1; load_addr = 4'(a); load_sym = 3'(v);
        tape_m[a] = 3'(v);
        @(negedge clock);
        load_we = 1'b0;
    endtask

    task automatic run(input int h0, input int lim, input bit do_load,
                       input int la, input int lv, output int s);
        @(negedge clock);
        start = 1'b1; start_head = 4'(h0); step_limit = 16'(lim);
        load_we = do_load; load_addr = 4'(la); load_sym = 3'(lv);
        if (do_load) tape_m[la] = 3'(lv);
        s = cyc;
        model_run(h0, lim, s);
        @(negedge clock);
        start = 1'b0; load_we = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < MAXSTEPS * PERIOD + 20) begin
            @(negedge clock);
            n++;
        end
        chk("run_timeout", int'(busy), 0);
    endtask

    task automatic tape_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            load_addr = 4'(i);
            #1;
            chk($sformatf("%s_tape%0d", tag, i), int'(rd_sym), int'(tape_m[i]));
        end
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_halted"}, int'(halted), 0);
        chk({tag, "_fault"}, int'(fault), 0);
        chk({tag, "_head"}, int'(head), 0);
        chk({tag, "_step_count"}, int'(step_count), 0);
        chk({tag, "_core_sym"}, int'(core_sym), 0);
        chk({tag, "_valid"}, int'(core_sym_valid), 0);
    endtask

    initial begin
        int s;
        int n;
        for (int i = 0; i < DEPTH; i++) tape_m[i] = '0;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle_outputs("reset");
        tape_check("reset");
        repeat (20) @(negedge clock);

        // Load in the same cycle as start; halt on the third step.
        fill_resp(0);
        resp_sym[0] = 3'd2; resp_dir[0] = 1'b1;
        resp_sym[1] = 3'd4; resp_dir[1] = 1'b1;
        resp_sym[2] = HALT; resp_dir[2] = 1'b0;
        run(3, 0, 1'b1, 3, 1, s);
        load_addr = 4'd3;
        n = 0;
        while (cyc < s + 12 && n < 40) begin @(negedge clock); n++; end
        #1;
        chk("step1_head", int'(head), 4);
        chk("step1_step_count", int'(step_count), 1);
        chk("step1_tape3", int'(rd_sym), 2);
        wait_idle();
        tape_check("halt");

        // Left and right edge faults.
        fill_resp(0);
        resp_sym[0] = 3'd5; resp_dir[0] = 1'b0;
        run(0, 0, 1'b0, 0, 0, s);
        wait_idle();
        tape_check("left");
        fill_resp(0);
        resp_sym[0] = 3'd6; resp_dir[0] = 1'b1;
        run(15, 0, 1'b0, 0, 0, s);
        wait_idle();
        tape_check("right");

        // Step limit of 4, then a repeat with start/load attempts while busy.
        for (int k = 0; k < MAXSTEPS; k++) begin
            resp_sym[k] = 3'(k % 7);
            resp_dir[k] = 1'(k % 2);
        end
        resp_sym[0] = 3'd1;
        run(8, 4, 1'b0, 0, 0, s);
        wait_idle();
        run(8, 4, 1'b0, 0, 0, s);
        repeat (5) @(negedge clock);
        start = 1'b1; start_head = 4'd1; step_limit = 16'd0;
        load_we = 1'b1; load_addr = 4'd8; load_sym = 3'd3;
        @(negedge clock);
        start = 1'b0; load_we = 1'b0;
        wait_idle();
        tape_check("limit");

        // Reset while waiting on the second step.
        fill_resp(0);
        run(5, 0, 1'b0, 0, 0, s);
        n = 0;
        while (cyc < s + 15 && n < 40) begin @(negedge clock); n++; end
        pq.delete();
        sq.delete();
        sq.push_back('{0, 0, 0, 0});
        for (int i = 0; i < DEPTH; i++) tape_m[i] = '0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle_outputs("midreset");
        tape_check("midreset");

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            int h0;
            for (int w = 0; w < 3; w++) host_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 6));
            fill_resp(8);
            h0 = $urandom_range(0, DEPTH - 1);
            run(h0, $urandom_range(0, 6), 1'($urandom_range(0, 1)), h0, $urandom_range(0, 6), s);
            wait_idle();
            tape_check($sformatf("rand%0d", r));
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
